bar_level_meter: RTL and testbench



---
 rtl/bar_level_meter.sv | 183 ++++++++++++++++++
 tb/tb_bar_level_meter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/bar_level_meter.sv
// bar_level_meter
//   Turns the audio sample stream into one smoothed target bar height per
//   frame. Each frame window tracks the peak absolute sample magnitude.
//   At frame_tick the peak is scaled, clamped and smoothed: the bar rises
//   to the new height at once and falls by at most DECAY_STEP per frame.
//   The result is then emitted with a one-cycle valid pulse.
//
//   Optional feature macro: PEAK_HOLD_EN. When it is defined, a peak marker
//   holds for HOLD_FRAMES frames and then decays. When it is undefined,
//   peak_height simply follows target_height.
//
// Ports
//   Clk           in   system clock, rising edge
//   Reset         in   asynchronous, active-low reset
//   sample        in   signed audio sample (SAMPLE_W)
//   sample_valid  in   sample present
//   sample_ready  out  sample accepted this cycle (only while accumulating)
//   frame_tick    in   one-cycle end-of-frame strobe
//   target_height out  smoothed target height (HEIGHT_W)
//   target_valid  out  one-cycle pulse, target_height updated
//   peak_height   out  peak marker height (HEIGHT_W)
//   overrun       out  sticky: frame_tick arrived while busy
module bar_level_meter #(
  parameter int SAMPLE_W    = 16,
  parameter int HEIGHT_W    = 10,
  parameter int MAX_HEIGHT  = 50,
  parameter int MIN_HEIGHT  = 2,
  parameter int SCALE_SHIFT = 9,
  parameter int DECAY_STEP  = 1,
  parameter int HOLD_FRAMES = 8
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic signed [SAMPLE_W-1:0] sample,
  input  logic                       sample_valid,
  output logic                       sample_ready,
  input  logic                       frame_tick,
  output logic [HEIGHT_W-1:0]        target_height,
  output logic                       target_valid,
  output logic [HEIGHT_W-1:0]        peak_height,
  output logic                       overrun
);

  // A magnitude never exceeds 2^(SAMPLE_W-1)-1, so one bit less suffices.
  localparam int MAG_W = SAMPLE_W - 1;
  localparam logic [MAG_W-1:0]    MAX_M = MAG_W'(MAX_HEIGHT);
  localparam logic [MAG_W-1:0]    MIN_M = MAG_W'(MIN_HEIGHT);
  localparam logic [HEIGHT_W-1:0] MIN_H = HEIGHT_W'(MIN_HEIGHT);
  localparam logic [HEIGHT_W-1:0] DEC_H = HEIGHT_W'(DECAY_STEP);
  localparam logic [HEIGHT_W:0]   DEC_X = (HEIGHT_W + 1)'(DECAY_STEP);

  typedef enum logic [1:0] {ACCUM, SCALE, UPDATE, EMIT} state_t;

  state_t              state_q, state_d;
  logic [MAG_W-1:0]    win_max_q, win_max_d;
  logic [HEIGHT_W-1:0] new_h_q, new_h_d;
  logic [HEIGHT_W-1:0] target_q, target_d;
  logic [HEIGHT_W-1:0] peak_q, peak_d;
  logic                overrun_q, overrun_d;

  logic [SAMPLE_W-1:0] neg_s;
  logic [MAG_W-1:0]    mag;
  logic [MAG_W-1:0]    shifted;
  logic [MAG_W-1:0]    clamped;
  logic [HEIGHT_W-1:0] target_upd;
  logic                accept;

  // Absolute value. Negating the most-negative sample wraps back to a
  // negative number, which is detected and saturated to all ones.
  assign neg_s = SAMPLE_W'(-sample);
  always_comb begin
    mag = sample[MAG_W-1:0];
    if (sample[SAMPLE_W-1]) begin
      mag = neg_s[SAMPLE_W-1] ? {MAG_W{1'b1}} : neg_s[MAG_W-1:0];
    end
  end

  // The clamp runs at full magnitude width. A huge peak therefore cannot
  // alias to a small height after truncation.
  assign shifted = win_max_q >> SCALE_SHIFT;
  always_comb begin
    clamped = shifted;
    if (shifted > MAX_M) clamped = MAX_M;
    if (shifted < MIN_M) clamped = MIN_M;
  end

  // Attack immediately. The decay is limited to DECAY_STEP and never goes
  // below new_h. The compare is widened so the subtraction cannot underflow.
  always_comb begin
    target_upd = new_h_q;
    if (new_h_q < target_q &&
        {1'b0, target_q} > ({1'b0, new_h_q} + DEC_X)) begin
      target_upd = target_q - DEC_H;
    end
  end

  assign sample_ready = (state_q == ACCUM) && Reset;
  assign accept       = sample_valid && sample_ready;

  always_comb begin
    state_d   = state_q;
    win_max_d = win_max_q;
    new_h_d   = new_h_q;
    target_d  = target_q;
    overrun_d = overrun_q;
    case (state_q)
      ACCUM: begin
        if (accept && mag > win_max_q) win_max_d = mag;
        if (frame_tick) state_d = SCALE;
      end
      SCALE: begin
        new_h_d   = HEIGHT_W'(clamped);
        win_max_d = '0;
        state_d   = UPDATE;
      end
      UPDATE: begin
        target_d = target_upd;
        state_d  = EMIT;
      end
      EMIT:    state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
    // A tick while the pipeline is busy cannot start a second update.
    if (frame_tick && state_q != ACCUM) overrun_d = 1'b1;
  end

`ifdef PEAK_HOLD_EN
  localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_FRAMES);
  logic [HOLD_W-1:0] hold_q, hold_d;

  always_comb begin
    peak_d = peak_q;
    hold_d = hold_q;
    if (state_q == UPDATE) begin
      if (target_d > peak_q) begin
        peak_d = target_d;
        hold_d = HOLD_INIT;
      end else if (hold_q != '0) begin
        hold_d = hold_q - 1'b1;
      end else if ({1'b0, peak_q} > ({1'b0, target_d} + DEC_X)) begin
        peak_d = peak_q - DEC_H;
      end else begin
        peak_d = target_d;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) hold_q <= '0;
    else        hold_q <= hold_d;
  end
`else
  always_comb begin
    peak_d = peak_q;
    if (state_q == UPDATE) peak_d = target_d;
  end
`endif

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= ACCUM;
      win_max_q <= '0;
      new_h_q   <= MIN_H;
      target_q  <= MIN_H;
      peak_q    <= MIN_H;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_max_q <= win_max_d;
      new_h_q   <= new_h_d;
      target_q  <= target_d;
      peak_q    <= peak_d;
      overrun_q <= overrun_d;
    end
  end

  assign target_height = target_q;
  assign peak_height   = peak_q;
  assign target_valid  = (state_q == EMIT);
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_bar_level_meter.sv
module tb_bar_level_meter;

  logic               Clk = 1'b0;
  logic               Reset;
  logic signed [15:0] sample;
  logic               sample_valid;
  logic               sample_ready;
  logic               frame_tick;
  logic [9:0]         target_height;
  logic               target_valid;
  logic [9:0]         peak_height;
  logic               overrun;

  int n_cmp = 0;
  int n_err = 0;

  always #5 Clk = ~Clk;

  bar_level_meter dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .sample       (sample),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .frame_tick   (frame_tick),
    .target_height(target_height),
    .target_valid (target_valid),
    .peak_height  (peak_height),
    .overrun      (overrun)
  );

  typedef struct {
    int               n;      // samples offered in this window
    logic [2:0][15:0] s;      // s[0] goes first
    int               exp_t;  // expected target_height at t+3
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Offer n samples, then pulse frame_tick. Check the three busy cycles,
  // the valid pulse at t+3, and the return to ACCUM.
  task automatic run_frame(input int n, input logic [2:0][15:0] s,
                           input int exp_t, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      sample = s[i];
      sample_valid = 1'b1;
      check({tag, " ready_accum"}, int'(sample_ready), 1);
    end
    @(negedge Clk);
    sample_valid = 1'b0;
    frame_tick = 1'b1;
    @(negedge Clk);
    frame_tick = 1'b0;
    check({tag, " valid_t1"}, int'(target_valid), 0);
    check({tag, " ready_t1"}, int'(sample_ready), 0);
    @(negedge Clk);
    check({tag, " valid_t2"}, int'(target_valid), 0);
    @(negedge Clk);
    check({tag, " valid_t3"}, int'(target_valid), 1);
    check({tag, " ready_t3"}, int'(sample_ready), 0);
    check({tag, " target"}, int'(target_height), exp_t);
`ifndef PEAK_HOLD_EN
    check({tag, " peak"}, int'(peak_height), exp_t);
`endif
    @(negedge Clk);
    check({tag, " valid_t4"}, int'(target_valid), 0);
    check({tag, " ready_t4"}, int'(sample_ready), 1);
  endtask

  vec_t vecs[14];

  initial begin
    int pulses;

    vecs[0]  = '{0, {16'h0, 16'h0, 16'h0}, 2};
    vecs[1]  = '{0, {16'h0, 16'h0, 16'h0}, 2};
    vecs[2]  = '{0, {16'h0, 16'h0, 16'h0}, 2};
    vecs[3]  = '{3, {16'h0800, 16'hE000, 16'h1000}, 16};   // 8192>>9
    vecs[4]  = '{1, {16'h0, 16'h0, 16'h8000}, 50};         // saturate, clamp
    vecs[5]  = '{0, {16'h0, 16'h0, 16'h0}, 49};
    vecs[6]  = '{0, {16'h0, 16'h0, 16'h0}, 48};
    vecs[7]  = '{0, {16'h0, 16'h0, 16'h0}, 47};
    vecs[8]  = '{0, {16'h0, 16'h0, 16'h0}, 46};
    vecs[9]  = '{0, {16'h0, 16'h0, 16'h0}, 45};
    vecs[10] = '{1, {16'h0, 16'h0, 16'h01FF}, 44};         // 0 -> MIN, decay
    vecs[11] = '{1, {16'h0, 16'h0, 16'h7FFF}, 50};         // 63 -> 50
    vecs[12] = '{1, {16'h0, 16'h0, 16'hE200}, 49};         // 15 < 49, decay
    vecs[13] = '{2, {16'h0, 16'h0300, 16'hFC00}, 48};      // 2, decay

    Reset = 1'b0;
    sample = '0;
    sample_valid = 1'b0;
    frame_tick = 1'b0;
    repeat (3) @(negedge Clk);
    check("rst ready", int'(sample_ready), 0);
    check("rst target", int'(target_height), 2);
    check("rst peak", int'(peak_height), 2);
    check("rst valid", int'(target_valid), 0);
    check("rst overrun", int'(overrun), 0);
    Reset = 1'b1;
    @(negedge Clk);
    check("post-rst ready", int'(sample_ready), 1);

    for (int i = 0; i < 14; i++) begin
      run_frame(vecs[i].n, vecs[i].s, vecs[i].exp_t, $sformatf("vec%0d", i));
      $display("vec %0d: target_height=%0d peak_height=%0d", i, target_height, peak_height);
    end

    // Reset mid-window throws away the partial window.
    @(negedge Clk);
    sample = 16'h7FFF;
    sample_valid = 1'b1;
    @(negedge Clk);
    sample_valid = 1'b0;
    Reset = 1'b0;
    #1;
    check("midrst target", int'(target_height), 2);
    check("midrst ready", int'(sample_ready), 0);
    @(negedge Clk);
    Reset = 1'b1;
    run_frame(0, '0, 2, "midrst empty");
    $display("midrst: target_height=%0d", target_height);

    // A sample handshaken with frame_tick belongs to the closing window.
    // A sample held during busy cycles waits and is then accepted.
    @(negedge Clk);
    sample = 16'h1400;
    sample_valid = 1'b1;
    frame_tick = 1'b1;
    check("same ready", int'(sample_ready), 1);
    @(negedge Clk);
    frame_tick = 1'b0;
    sample = 16'h7FFF;
    check("same busy1 ready", int'(sample_ready), 0);
    @(negedge Clk);
    check("same busy2 ready", int'(sample_ready), 0);
    @(negedge Clk);
    check("same busy3 ready", int'(sample_ready), 0);
    check("same valid", int'(target_valid), 1);
    check("same target", int'(target_height), 10);
    @(negedge Clk);
    check("held ready", int'(sample_ready), 1);
    run_frame(0, '0, 50, "held");
    $display("same-cycle: target_height=%0d", target_height);

    // A second tick while in SCALE sets overrun and causes no extra update.
    check("pre overrun", int'(overrun), 0);
    @(negedge Clk);
    frame_tick = 1'b1;
    @(negedge Clk);
    pulses = 0;
    @(negedge Clk);
    frame_tick = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (target_valid) pulses++;
      @(negedge Clk);
    end
    check("ovr pulses", pulses, 1);
    check("ovr set", int'(overrun), 1);
    check("ovr target", int'(target_height), 49);
    run_frame(0, '0, 48, "ovr next");
    check("ovr sticky", int'(overrun), 1);
    Reset = 1'b0;
    @(negedge Clk);
    check("ovr cleared", int'(overrun), 0);
    Reset = 1'b1;
    $display("overrun: pulses=%0d", pulses);

`ifdef PEAK_HOLD_EN
    // 0x5000 >> 9 = 40. The peak holds for 8 frames and then decays by one.
    @(negedge Clk);
    run_frame(1, {16'h0, 16'h0, 16'h5000}, 40, "hold up");
    check("hold peak0", int'(peak_height), 40);
    for (int k = 1; k <= 10; k++) begin
      run_frame(0, '0, 40 - k, $sformatf("hold%0d", k));
      check($sformatf("hold%0d peak", k), int'(peak_height),
            (k <= 8) ? 40 : 40 - (k - 8));
      $display("hold frame %0d: target=%0d peak=%0d", k, target_height, peak_height);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
